clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Generates the two single-cycle clock enables that pace the SAP-1 datapath and controller from the free-running `sysclk`: `clken` (virtual rising edge; registers latch) and `clken_oop` (virtual falling edge; controller T-state advances). It supports free-run, single-step and halt operation. It sits directly upstream of the control unit, consumes that unit's `halt` flag, and drives its `clken`/`clken_oop` inputs.

## Interface
- `DIV`, default 4: `sysclk` cycles per machine cycle; even, ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: stable-input cycles required by the step debouncer; used only when `STEP_DEBOUNCE_EN` is defined.
- `sysclk` input, 1 bit: the single clock for the block.
- `clear` input, 1 bit: reset, synchronous and active-high.
- `run_mode` input, 1 bit: 1 selects free-run; 0 selects single-step.
- `step_btn` input, 1 bit: raw, asynchronous step request; active-high.
- `halt` input, 1 bit: halt request from the control unit.
- `clken` output, 1 bit: one-cycle pulse at the virtual rising edge.
- `clken_oop` output, 1 bit: one-cycle pulse at the virtual falling edge.
- `vclk` output, 1 bit: virtual clock level for display only; high while `cnt` is in [DIV/2, DIV-1].
- `halted` output, 1 bit: high while in HALTED.
- `cycle_count` output, 16 bits: number of completed machine cycles.

## Operation
- Phase counter `cnt`, width clog2(DIV):
  - counts 0..DIV-1 and wraps;
  - held at 0 in STOPPED and HALTED.
- Enable decode, asserted only in RUN or STEP:
  - `clken` = (cnt == DIV/2-1);
  - `clken_oop` = (cnt == DIV-1).
  - The two enables are never high in the same cycle.
- States:
  - **STOPPED:**
    - `run_mode`=1 → RUN.
    - Else, step edge with `halt`=0 → STEP.
    - Else, step edge with `halt`=1 → HALTED, with no pulses issued.
  - **RUN:** free-running. On a `clken_oop` cycle:
    - `halt`=1 → HALTED;
    - else `run_mode`=0 → STOPPED;
    - else stay in RUN.
  - **STEP:** runs exactly one machine cycle (one `clken`, then one `clken_oop`). On the `clken_oop` cycle → HALTED if `halt`=1, else STOPPED.
  - **HALTED:** terminal. No enables are issued; `run_mode` and `step_btn` are ignored. Only `clear` exits.
- Mode changes take effect only at machine-cycle boundaries. A partially completed machine cycle is never truncated.
- Step request path:
  - 2-flop synchroniser, then an optional debouncer, then a rising-edge detector producing a one-cycle `step_edge`.
  - `step_edge` is acted on only in STOPPED. Edges arriving in RUN, STEP or HALTED are dropped, not queued.
- `halt` is sampled only on `clken_oop` cycles (plus the STOPPED step check). Glitches between those samples are ignored.
- `cycle_count` increments on every `clken_oop` pulse and wraps 0xFFFF → 0x0000.

## Timing
- Reset: `clear`=1 at a `sysclk` edge sets, by the next cycle:
  - state = STOPPED, `cnt`=0;
  - `clken`=`clken_oop`=`vclk`=`halted`=0, `cycle_count`=0;
  - synchroniser, debouncer and edge registers = 0.
- Reset mid-cycle discards the partial machine cycle. `clear` has priority over every other input.
- Entry into RUN or STEP occurs with `cnt`=0. From that cycle:
  - first `clken` comes DIV/2-1 cycles later;
  - `clken_oop` comes DIV-1 cycles later.
- STEP exits on the cycle after `clken_oop`.
- Step latency without debounce: `step_btn` rising before edge n → `step_edge` in cycle n+3 → STEP in n+4.
- Step latency with debounce: an additional DEBOUNCE_CYCLES.
- RUN steady state: enable pulses every DIV cycles, with `clken` leading `clken_oop` by DIV/2.

## Configuration
- `STEP_DEBOUNCE_EN` defined:
  - `step_btn` must be stable for DEBOUNCE_CYCLES consecutive synchronised samples before the filtered level changes.
  - Bounces shorter than that produce no edge.
- `STEP_DEBOUNCE_EN` undefined:
  - the filtered level is the synchroniser output directly;
  - each synchronised rising edge is a step request.

## Structure
- Shared package `sap_pkg` holds:
  - state encoding constants (STOPPED, RUN, STEP, HALTED);
  - the `cycle_count` width;
  - the default DIV.
- Sub-module `step_debounce` holds the synchroniser, the debounce counter (present only when `STEP_DEBOUNCE_EN` is defined) and the edge detector. Its output is `step_edge`.

## Test plan
All scenarios use DIV=4.
- **Reset:** `clear` high for 3 cycles → all outputs 0, state STOPPED; no enable pulses while `run_mode`=0.
- **Free-run:** `run_mode`=1 for 40 cycles → `clken` at `cnt`=1 and `clken_oop` at `cnt`=3 every 4 cycles; `cycle_count`=10.
- **Single step:** `run_mode`=0, three clean `step_btn` pulses spaced 20 cycles apart → exactly 3 `clken` and 3 `clken_oop`, each `clken` 2 cycles before its `clken_oop`; `cycle_count`=3.
- **Halt:** in RUN, raise `halt` mid machine cycle → the current `clken_oop` still fires, then `halted`=1 with no further pulses; steps and `run_mode` toggles are ignored until `clear`.
- **Mode switch and dropped step:** drop `run_mode` at `cnt`=1 → machine cycle completes, then STOPPED; a step pulse issued during RUN produces no extra cycle.
- **Debounce (`STEP_DEBOUNCE_EN`, DEBOUNCE_CYCLES=16):** `step_btn` bouncing with 5-cycle pulses, then held high for 30 cycles → exactly one step cycle.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: controller state encoding, cycle-counter width
// and default machine-cycle divider.
package sap_pkg;

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    localparam int CYCLE_COUNT_W           = 16;
    localparam int DEFAULT_DIV             = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/step_debounce.sv
// Step-button conditioning: 2-flop synchroniser, optional stable-level filter
// (STEP_DEBOUNCE_EN) and rising-edge detector producing a one-cycle step_edge.
module step_debounce
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic sysclk,
    input  logic clear,
    input  logic step_btn,
    output logic step_edge
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic level_prev_q;
    logic step_edge_q;

    // NOTE: sequential state is always assigned with <=, so every flop samples
    // the pre-edge value of its neighbour and the synchroniser really is two stages.
    always_ff @(posedge sysclk) begin
        if (clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            level_q;
    logic            level_d;

    // Counter tracks consecutive samples that disagree with the filtered level.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (clear) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;
`else
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    assign level = sync2_q;
`endif

    always_ff @(posedge sysclk) begin
        if (clear) begin
            level_prev_q <= 1'b0;
            step_edge_q  <= 1'b0;
        end else begin
            level_prev_q <= level;
            step_edge_q  <= level & ~level_prev_q;
        end
    end

    assign step_edge = step_edge_q;

endmodule

// File: rtl/clock_enable_gen.sv
// SAP-1 clock-enable generator: clken / clken_oop pacing with free-run,
// single-step and halt. Define STEP_DEBOUNCE_EN to filter the step button.
module clock_enable_gen
    import sap_pkg::*;
#(
    parameter int DIV             = DEFAULT_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                     sysclk,
    input  logic                     clear,
    input  logic                     run_mode,
    input  logic                     step_btn,
    input  logic                     halt,
    output logic                     clken,
    output logic                     clken_oop,
    output logic                     vclk,
    output logic                     halted,
    output logic [CYCLE_COUNT_W-1:0] cycle_count
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DIV / 2);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("DIV must be even and at least 2");
    end

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [CYCLE_COUNT_W-1:0] cycle_count_q;
    logic [CYCLE_COUNT_W-1:0] cycle_count_d;
    logic                     active;
    logic                     step_edge;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .sysclk    (sysclk),
        .clear     (clear),
        .step_btn  (step_btn),
        .step_edge (step_edge)
    );

    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign clken     = active && (cnt_q == CNT_RISE);
    assign clken_oop = active && (cnt_q == CNT_FALL);
    assign vclk      = (cnt_q >= CNT_HIGH);
    assign halted    = (state_q == ST_HALTED);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        cycle_count_d = cycle_count_q;

        if (active && cnt_q != CNT_FALL) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clken_oop) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end

        // Transitions out of RUN/STEP only on the closing clken_oop cycle,
        // so a machine cycle is never cut short.
        case (state_q)
            ST_STOPPED: begin
                if (run_mode) begin
                    state_d = ST_RUN;
                end else if (step_edge) begin
                    state_d = halt ? ST_HALTED : ST_STEP;
                end
            end
            ST_RUN: begin
                if (clken_oop) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (!run_mode) begin
                        state_d = ST_STOPPED;
                    end
                end
            end
            ST_STEP: begin
                if (clken_oop) begin
                    state_d = halt ? ST_HALTED : ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (clear) begin
            state_q       <= ST_STOPPED;
            cnt_q         <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed self-checking bench for clock_enable_gen with DIV=4.
module tb_clock_enable_gen;

    logic        sysclk;
    logic        clear;
    logic        run_mode;
    logic        step_btn;
    logic        halt;
    logic        clken;
    logic        clken_oop;
    logic        vclk;
    logic        halted;
    logic [15:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    int cyc            = 0;
    int n_clken        = 0;
    int n_oop          = 0;
    int n_gap_err      = 0;
    int n_overlap      = 0;
    int last_clken_cyc = -100;

    int b_clken;
    int b_oop;
    int b_gap;
    int b_ovl;

    clock_enable_gen #(
        .DIV             (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .sysclk      (sysclk),
        .clear       (clear),
        .run_mode    (run_mode),
        .step_btn    (step_btn),
        .halt        (halt),
        .clken       (clken),
        .clken_oop   (clken_oop),
        .vclk        (vclk),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Pulse bookkeeping on the falling edge, away from the active edge.
    always @(negedge sysclk) begin
        cyc = cyc + 1;
        if (clken && clken_oop) n_overlap = n_overlap + 1;
        if (clken) begin
            n_clken        = n_clken + 1;
            last_clken_cyc = cyc;
        end
        if (clken_oop) begin
            n_oop = n_oop + 1;
            if (cyc - last_clken_cyc != 2) n_gap_err = n_gap_err + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sysclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_clken = n_clken;
        b_oop   = n_oop;
        b_gap   = n_gap_err;
        b_ovl   = n_overlap;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(2);
        clear = 1'b0;
    endtask

    initial begin
        clear    = 1'b1;
        run_mode = 1'b0;
        step_btn = 1'b0;
        halt     = 1'b0;

        // Reset
        tick(3);
        clear = 1'b0;
        check("rst_clken", clken, 0);
        check("rst_oop", clken_oop, 0);
        check("rst_vclk", vclk, 0);
        check("rst_halted", halted, 0);
        check("rst_count", cycle_count, 0);
        snap();
        tick(10);
        check("stopped_no_clken", n_clken - b_clken, 0);
        check("stopped_no_oop", n_oop - b_oop, 0);

        // Free-run: 40 cycles, phase checks on the first machine cycle
        snap();
        run_mode = 1'b1;
        tick(2);
        check("run_c1_clken", clken, 1);
        check("run_c1_oop", clken_oop, 0);
        check("run_c1_vclk", vclk, 0);
        tick(1);
        check("run_c2_clken", clken, 0);
        check("run_c2_vclk", vclk, 1);
        tick(1);
        check("run_c3_oop", clken_oop, 1);
        check("run_c3_vclk", vclk, 1);
        tick(36);
        check("run_last_oop", clken_oop, 1);
        run_mode = 1'b0;
        tick(4);
        check("run_count", cycle_count, 10);
        check("run_n_clken", n_clken - b_clken, 10);
        check("run_n_oop", n_oop - b_oop, 10);
        check("run_gap", n_gap_err - b_gap, 0);
        check("run_overlap", n_overlap - b_ovl, 0);
        snap();
        tick(8);
        check("stop_after_run", n_oop - b_oop, 0);

        // Single step: three clean pulses 20 cycles apart
        do_clear();
        check("step_rst_count", cycle_count, 0);
        snap();
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1;
            tick(3);
            step_btn = 1'b0;
            if (i == 0) begin
                tick(1);
                check("step_lat_pre", clken, 0);
                tick(1);
                check("step_lat_clken", clken, 1);
                tick(15);
            end else begin
                tick(17);
            end
        end
        check("step_n_clken", n_clken - b_clken, 3);
        check("step_n_oop", n_oop - b_oop, 3);
        check("step_gap", n_gap_err - b_gap, 0);
        check("step_count", cycle_count, 3);
        check("step_halted", halted, 0);

        // Mode switch mid-cycle, with a step pulse dropped during RUN
        do_clear();
        snap();
        run_mode = 1'b1;
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        tick(3);
        check("ms_clken_at_drop", clken, 1);
        run_mode = 1'b0;
        tick(2);
        check("ms_oop_completes", clken_oop, 1);
        tick(10);
        check("ms_n_clken", n_clken - b_clken, 2);
        check("ms_n_oop", n_oop - b_oop, 2);
        check("ms_count", cycle_count, 2);

        // Halt raised mid machine cycle in RUN
        do_clear();
        snap();
        run_mode = 1'b1;
        tick(2);
        halt = 1'b1;
        tick(2);
        check("halt_oop_fires", clken_oop, 1);
        check("halt_not_yet", halted, 0);
        tick(1);
        check("halt_entered", halted, 1);
        check("halt_no_clken", clken, 0);
        halt     = 1'b0;
        run_mode = 1'b0;
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        tick(6);
        run_mode = 1'b1;
        tick(10);
        check("halt_sticky", halted, 1);
        check("halt_n_clken", n_clken - b_clken, 1);
        check("halt_n_oop", n_oop - b_oop, 1);
        check("halt_count", cycle_count, 1);
        run_mode = 1'b0;
        do_clear();
        check("halt_cleared", halted, 0);
        check("halt_clr_count", cycle_count, 0);

        // Step edge while halt is asserted goes straight to HALTED
        snap();
        halt     = 1'b1;
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        tick(5);
        check("stphalt_halted", halted, 1);
        check("stphalt_no_pulse", n_clken - b_clken + n_oop - b_oop, 0);
        halt = 1'b0;
        do_clear();

        // Reset in the middle of a RUN machine cycle
        run_mode = 1'b1;
        tick(3);
        check("midrst_vclk_pre", vclk, 1);
        clear    = 1'b1;
        run_mode = 1'b0;
        tick(1);
        check("midrst_vclk", vclk, 0);
        check("midrst_oop", clken_oop, 0);
        check("midrst_count", cycle_count, 0);
        clear = 1'b0;
        tick(2);

`ifdef STEP_DEBOUNCE_EN
        // Bouncing button then a solid press: one step only
        snap();
        for (int i = 0; i < 4; i++) begin
            step_btn = 1'b1;
            tick(5);
            step_btn = 1'b0;
            tick(5);
        end
        step_btn = 1'b1;
        tick(30);
        step_btn = 1'b0;
        tick(40);
        check("db_n_clken", n_clken - b_clken, 1);
        check("db_n_oop", n_oop - b_oop, 1);
        check("db_count", cycle_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
